// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeds an LSB-first serializer.
// The state encoding and parameter set are shared with uart_rx so the two can be looped back directly.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLK_RATE   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [7:0]                    data_in,
  input  logic                          data_wr,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx,
  output logic                          busy,
  output logic [1:0]                    state_bits
);
  localparam int CLOCKS_PER_BIT = CLK_RATE / BAUD_RATE;
  localparam int CNT_W          = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b11,
    STOP  = 2'b10
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_busy;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_bit_end;
  logic w_push;
  logic w_pop;

  // Pop decisions use the count before this edge, so a byte written now is first seen next cycle.
  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == {(PTR_W + 1){1'b0}});
  assign w_bit_end = (r_baud_cnt == CNT_LAST);
  assign w_push    = data_wr && !w_full;
  assign w_pop     = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

  assign ready      = !w_full;
  assign fifo_count = r_count;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign state_bits = r_state;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {(PTR_W + 1){1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_in;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Serializer FSM; tx and busy are set on the edge that enters each state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_baud_cnt <= {CNT_W{1'b0}};
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_baud_cnt <= {CNT_W{1'b0}};
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_baud_cnt <= {CNT_W{1'b0}};
            r_bit_idx  <= 3'd0;
            r_state    <= DATA;
            r_tx       <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= {CNT_W{1'b0}};
            r_shift    <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= {CNT_W{1'b0}};
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_baud_cnt <= {CNT_W{1'b0}};
          r_bit_idx  <= 3'd0;
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-timing reference model (byte queue + time within frame)
// and a mid-bit sampling receiver check the line cycle by cycle and byte by byte.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  // Small, non-power-of-two bit period (12 clocks, truncated division) keeps the run short
  localparam int CLK_RATE  = 1000000;
  localparam int BAUD_RATE = 77000;
  localparam int DEPTH     = 4;
  localparam int CPB       = CLK_RATE / BAUD_RATE;
  localparam int FRAME     = 10 * CPB;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic          clk     = 1'b0;
  logic          rstn    = 1'b0;
  logic          data_wr = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic          ready;
  logic [CW-1:0] fifo_count;
  logic          tx;
  logic          busy;
  logic [1:0]    state_bits;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_acc[$];
  logic [7:0] rx_q[$];
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;

  uart_tx_fifo #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .data_in(data_in), .data_wr(data_wr), .ready(ready),
    .fifo_count(fifo_count), .tx(tx), .busy(busy), .state_bits(state_bits)
  );

  always #5 clk = ~clk;

  // Reference receiver: samples mid-bit after a falling edge, drops frames cut by reset
  initial begin : rx_mon
    logic [7:0] b;
    bit ab;
    forever begin
      @(negedge tx);
      ab = 1'b0;
      repeat (CPB / 2) begin @(posedge clk); if (!rstn) ab = 1'b1; end
      if (tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(posedge clk); if (!rstn) ab = 1'b1; end
          b[i] = tx;
        end
        repeat (CPB) begin @(posedge clk); if (!rstn) ab = 1'b1; end
        if (tx === 1'b1 && !ab) rx_q.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [CW+4:0] exp_vec();
    int k;
    logic t;
    logic [1:0] s;
    if (!m_active) begin
      t = 1'b1; s = 2'b00;
    end else begin
      k = m_t / CPB;
      if (k == 0)      begin t = 1'b0;          s = 2'b01; end
      else if (k == 9) begin t = 1'b1;          s = 2'b10; end
      else             begin t = m_byte[k - 1]; s = 2'b11; end
    end
    return {t, m_active, s, (m_q.size() < DEPTH), CW'(m_q.size())};
  endfunction

  function automatic logic [CW+4:0] dut_vec();
    return {tx, busy, state_bits, ready, fifo_count};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_byte   = 8'h00;
  endtask

  // One clock: the model applies the frame rules at the active edge, then returns at the falling edge
  task automatic tick();
    int pre;
    bit last;
    bit pop;
    @(posedge clk);
    pre  = m_q.size();
    last = m_active && (m_t == FRAME - 1);
    pop  = (pre > 0) && (!m_active || last);
    if (pop) begin
      m_byte = m_q.pop_front(); m_active = 1'b1; m_t = 0;
    end else if (last) begin
      m_active = 1'b0; m_t = 0;
    end else if (m_active) begin
      m_t++;
    end
    if (data_wr && pre < DEPTH) begin
      m_q.push_back(data_in);
      m_acc.push_back(data_in);
    end
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    data_wr = 1'b1;
    data_in = b;
    tick();
    data_wr = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #100;
    n_vec++;
    if (dut_vec() !== {1'b1, 1'b0, 2'b00, 1'b1, CW'(0)}) begin
      n_err++; $display("FAIL reset_values: got %b want %b", dut_vec(), {1'b1, 1'b0, 2'b00, 1'b1, CW'(0)});
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 5 * CPB; c++) begin
      tick();
      n_vec++;
      if (tx !== 1'b1 || dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_quiet cycle %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    rx_q.delete(); m_acc.delete();
    write_byte(8'h55);
    n_vec++;
    if (fifo_count !== CW'(1) || state_bits !== 2'b00) begin
      n_err++; $display("FAIL single_write: count %0d state %b want 1 00", fifo_count, state_bits);
    end
    for (int c = 0; c < FRAME; c++) begin
      tick();
      n_vec++;
      if (tx !== 1'((c / CPB) % 2)) begin
        n_err++; $display("FAIL single_tx cycle %0d: got %b want %b", c, tx, 1'((c / CPB) % 2));
      end
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL single_vec cycle %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || state_bits !== 2'b00 || tx !== 1'b1) begin
      n_err++; $display("FAIL single_idle: busy %b state %b tx %b want 0 00 1", busy, state_bits, tx);
    end
    n_vec++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      n_err++; $display("FAIL single_rx: got %0d bytes first %h want 1 byte 55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
    end
  endtask

  task automatic test_burst();
    logic [7:0] bytes [4] = '{8'h55, 8'hFF, 8'h00, 8'hF0};
    int counts [4] = '{1, 1, 2, 3};
    int first_b = -1;
    int last_b = -1;
    int n_busy = 0;
    int t = 0;
    rx_q.delete(); m_acc.delete();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i]);
      if (busy === 1'b1) begin n_busy++; if (first_b < 0) first_b = t; last_b = t; end
      t++;
      n_vec++;
      if (fifo_count !== CW'(counts[i]) || dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL burst_count %0d: got %0d want %0d", i, fifo_count, counts[i]);
      end
    end
    for (int c = 0; c < 5 * FRAME && (m_active || m_q.size() > 0); c++) begin
      tick();
      if (busy === 1'b1) begin n_busy++; if (first_b < 0) first_b = t; last_b = t; end
      t++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL burst_vec cycle %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (n_busy != 4 * FRAME || last_b - first_b + 1 != n_busy) begin
      n_err++; $display("FAIL burst_busy: busy cycles %0d span %0d want %0d contiguous", n_busy, last_b - first_b + 1, 4 * FRAME);
    end
    n_vec++;
    if (rx_q.size() != 4) begin
      n_err++; $display("FAIL burst_rx_len: got %0d want 4", rx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (rx_q[i] !== bytes[i]) begin
          n_err++; $display("FAIL burst_rx %0d: got %h want %h", i, rx_q[i], bytes[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] want [5] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
    rx_q.delete(); m_acc.delete();
    write_byte(8'hA5);
    repeat (3) tick();
    for (int i = 1; i <= 6; i++) begin
      write_byte(8'(i));
      n_vec++;
      if (fifo_count !== CW'((i < 4) ? i : 4) || ready !== 1'(i < 4)) begin
        n_err++; $display("FAIL overflow_level %0d: count %0d ready %b want %0d %b", i, fifo_count, ready, (i < 4) ? i : 4, 1'(i < 4));
      end
    end
    for (int c = 0; c < 6 * FRAME && (m_active || m_q.size() > 0); c++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL overflow_vec cycle %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (rx_q.size() != 5) begin
      n_err++; $display("FAIL overflow_rx_len: got %0d want 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_vec++;
        if (rx_q[i] !== want[i]) begin
          n_err++; $display("FAIL overflow_rx %0d: got %h want %h", i, rx_q[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [7:0] want [3] = '{8'h11, 8'h22, 8'h33};
    rx_q.delete(); m_acc.delete();
    write_byte(8'h11);
    write_byte(8'h22);
    for (int c = 0; c < 2 * FRAME && !(m_active && m_t == FRAME - 1); c++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL collision_vec cycle %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (state_bits !== 2'b10 || fifo_count !== CW'(1)) begin
      n_err++; $display("FAIL collision_setup: state %b count %0d want 10 1", state_bits, fifo_count);
    end
    write_byte(8'h33);
    n_vec++;
    if (fifo_count !== CW'(1) || state_bits !== 2'b01 || tx !== 1'b0) begin
      n_err++; $display("FAIL collision_edge: count %0d state %b tx %b want 1 01 0", fifo_count, state_bits, tx);
    end
    for (int c = 0; c < 3 * FRAME && (m_active || m_q.size() > 0); c++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL collision_drain cycle %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (rx_q.size() != 3 || rx_q[0] !== want[0] || rx_q[1] !== want[1] || rx_q[2] !== want[2]) begin
      n_err++; $display("FAIL collision_rx: got %0d bytes want 11 22 33", rx_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    rx_q.delete(); m_acc.delete();
    write_byte(8'h3C);
    write_byte(8'hC3);
    write_byte(8'h5A);
    for (int c = 0; c < FRAME && !(m_active && m_t / CPB == 4); c++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL midrst_vec cycle %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (state_bits !== 2'b11 || fifo_count !== CW'(2)) begin
      n_err++; $display("FAIL midrst_setup: state %b count %0d want 11 2", state_bits, fifo_count);
    end
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if (tx !== 1'b1 || fifo_count !== CW'(0) || busy !== 1'b0 || state_bits !== 2'b00) begin
      n_err++; $display("FAIL midrst_async: tx %b count %0d busy %b state %b want 1 0 0 00", tx, fifo_count, busy, state_bits);
    end
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      n_vec++;
      if (tx !== 1'b1 || dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL midrst_quiet cycle %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (rx_q.size() != 0) begin
      n_err++; $display("FAIL midrst_nobytes: got %0d want 0", rx_q.size());
    end
    write_byte(8'h96);
    for (int c = 0; c < 2 * FRAME && (m_active || m_q.size() > 0); c++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL midrst_after cycle %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h96) begin
      n_err++; $display("FAIL midrst_rx: got %0d bytes want 1 byte 96", rx_q.size());
    end
  endtask

  task automatic test_random();
    rx_q.delete(); m_acc.delete();
    for (int c = 0; c < 400; c++) begin
      data_wr = ($urandom_range(0, 15) == 0);
      data_in = 8'($urandom);
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_vec cycle %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    data_wr = 1'b0;
    for (int c = 0; c < (DEPTH + 2) * FRAME && (m_active || m_q.size() > 0); c++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_drain cycle %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (rx_q.size() != m_acc.size()) begin
      n_err++; $display("FAIL random_rx_len: got %0d want %0d", rx_q.size(), m_acc.size());
    end else begin
      for (int i = 0; i < m_acc.size(); i++) begin
        n_vec++;
        if (rx_q[i] !== m_acc[i]) begin
          n_err++; $display("FAIL random_rx %0d: got %h want %h", i, rx_q[i], m_acc[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_collision();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
